// File: rtl/cp2_pkg.sv
// Shared definitions for the CP2 bus arbiter: FSM encoding, default widths and the
// CP2 CPU-visible register map used by software headers and the bench.
package cp2_pkg;

    localparam int CP2_AW = 32;
    localparam int CP2_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // CP2 register offsets (byte offsets from the CP2 base)
    localparam logic [7:0] CP2_REG_CTRL    = 8'h00;
    localparam logic [7:0] CP2_REG_STATUS  = 8'h04;
    localparam logic [7:0] CP2_REG_DMA_SRC = 8'h08;
    localparam logic [7:0] CP2_REG_DMA_DST = 8'h0C;
    localparam logic [7:0] CP2_REG_KEY     = 8'h10;

    localparam int CP2_STAT_INT_BIT  = 31;
    localparam int CP2_STAT_GO_BIT   = 30;
    localparam int CP2_STAT_HOLD_BIT = 24;

    function automatic logic cp2_owns_bus(input arb_state_t st);
        return st == ST_GRANT;
    endfunction

endpackage

// File: rtl/cp2_int_latch.sv
// Latches a rising edge of the CP2 INT level until the CPU acknowledges it.
// A new edge in the same cycle as an acknowledge keeps the interrupt pending.
module cp2_int_latch (
    input  logic clk,
    input  logic rst,
    input  logic cp2_int,
    input  logic int_ack,
    output logic int_pend
);

    logic int_prev;
    logic int_rise;

    assign int_rise = cp2_int & ~int_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_prev <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            int_prev <= cp2_int;
            if (int_rise)
                int_pend <= 1'b1;
            else if (int_ack)
                int_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/cp2_bus_arbiter.sv
// HOLD/HOLD_ACK arbiter handing the data memory between the CPU and the CP2 DMA port.
// Optional grant watchdog with sticky wdt_err is built when CP2_ARB_WDT_EN is defined.
module cp2_bus_arbiter
    import cp2_pkg::*;
#(
    parameter int AW        = CP2_AW,
    parameter int DW        = CP2_DW,
    parameter int DRAIN_MAX = 8,
    parameter int WDT_MAX   = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic          cpu_busy,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    input  logic          cp2_we,
    input  logic [AW-1:0] cp2_addr,
    input  logic [DW-1:0] cp2_wd,
    output logic [DW-1:0] cp2_rd,
    input  logic          HOLD,
    output logic          HOLD_ACK,
    input  logic          cp2_int,
    input  logic          int_ack,
    output logic          int_pend,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef CP2_ARB_WDT_EN
    ,
    output logic          wdt_err
`endif
);

    localparam int DCW = $clog2(DRAIN_MAX + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

    arb_state_t     state;
    logic [DCW-1:0] drain_cnt;

`ifdef CP2_ARB_WDT_EN
    localparam int WCW = $clog2(WDT_MAX + 1);
    localparam logic [WCW-1:0] WDT_LAST = WCW'(WDT_MAX - 1);

    logic [WCW-1:0] wdt_cnt;
    logic           wdt_block;   // HOLD ignored after a watchdog release until seen low
`else
    localparam logic wdt_block = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            HOLD_ACK  <= 1'b0;
            cpu_stall <= 1'b0;
            drain_cnt <= '0;
`ifdef CP2_ARB_WDT_EN
            wdt_cnt   <= '0;
            wdt_block <= 1'b0;
            wdt_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    drain_cnt <= '0;
`ifdef CP2_ARB_WDT_EN
                    if (!HOLD)
                        wdt_block <= 1'b0;
`endif
                    if (HOLD && !wdt_block) begin
                        state     <= ST_DRAIN;
                        cpu_stall <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt < DRAIN_LAST)
                        drain_cnt <= drain_cnt + 1'b1;
                    if (!HOLD) begin
                        state <= ST_RELEASE;
                    end else if (!cpu_busy || drain_cnt == DRAIN_LAST) begin
                        state    <= ST_GRANT;
                        HOLD_ACK <= 1'b1;
`ifdef CP2_ARB_WDT_EN
                        wdt_cnt  <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (!HOLD) begin
                        state    <= ST_RELEASE;
                        HOLD_ACK <= 1'b0;
                    end
`ifdef CP2_ARB_WDT_EN
                    else if (wdt_cnt == WDT_LAST) begin
                        state     <= ST_RELEASE;
                        HOLD_ACK  <= 1'b0;
                        wdt_err   <= 1'b1;
                        wdt_block <= 1'b1;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    // ST_RELEASE: one stalled cycle so a re-raised HOLD cannot chain grants
`ifdef CP2_ARB_WDT_EN
                    if (!HOLD)
                        wdt_block <= 1'b0;
`endif
                    state     <= ST_IDLE;
                    cpu_stall <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
        if (cp2_owns_bus(state)) begin
            mem_we   = cp2_we;
            mem_addr = cp2_addr;
            mem_wd   = cp2_wd;
        end else if (state != ST_IDLE) begin
            mem_we   = 1'b0;
        end
    end

    assign cpu_rd = mem_rd;
    assign cp2_rd = mem_rd;

    cp2_int_latch u_int_latch (
        .clk      (clk),
        .rst      (rst),
        .cp2_int  (cp2_int),
        .int_ack  (int_ack),
        .int_pend (int_pend)
    );

endmodule

// File: tb/tb_cp2_bus_arbiter.sv
// Directed bench for cp2_bus_arbiter; the watchdog scenario is included when
// CP2_ARB_WDT_EN is defined (instantiated with WDT_MAX=16).
module tb_cp2_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we, cpu_busy;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic        cpu_stall;
    logic        cp2_we;
    logic [31:0] cp2_addr, cp2_wd, cp2_rd;
    logic        HOLD, HOLD_ACK;
    logic        cp2_int, int_ack, int_pend;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef CP2_ARB_WDT_EN
    logic        wdt_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cp2_bus_arbiter #(.AW(32), .DW(32), .DRAIN_MAX(8), .WDT_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_busy(cpu_busy), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .cp2_we(cp2_we), .cp2_addr(cp2_addr), .cp2_wd(cp2_wd), .cp2_rd(cp2_rd),
        .HOLD(HOLD), .HOLD_ACK(HOLD_ACK),
        .cp2_int(cp2_int), .int_ack(int_ack), .int_pend(int_pend),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef CP2_ARB_WDT_EN
        , .wdt_err(wdt_err)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cpu_we = 0; cpu_busy = 0; cpu_addr = 0; cpu_wd = 0;
        cp2_we = 0; cp2_addr = 0; cp2_wd = 0;
        HOLD = 0; cp2_int = 0; int_ack = 0; mem_rd = 0;
        #1;
        n_chk++; if (HOLD_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b exp 0", HOLD_ACK); end
        n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
        n_chk++; if (int_pend !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b exp 0", int_pend); end
        tick(2);
        rst = 1'b0;
        tick(1);
        n_chk++; if (cpu_stall !== 1'b0 || HOLD_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_idle: stall %b ack %b exp 0 0", cpu_stall, HOLD_ACK); end
    endtask

    task automatic test_clean_grant;
        cpu_busy = 0; cpu_we = 1; cpu_addr = 32'h40; cpu_wd = 32'h11111111;
        cp2_we = 1; cp2_addr = 32'h100; cp2_wd = 32'hDEADBEEF;
        HOLD = 1;
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b0 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL grant_c1: ack %b stall %b exp 0 1", HOLD_ACK, cpu_stall); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL grant_drain_we: got %b exp 0", mem_we); end
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b1) begin n_fail++; $display("FAIL grant_c2_ack: got %b exp 1", HOLD_ACK); end
        n_chk++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wd !== 32'hDEADBEEF)
            begin n_fail++; $display("FAIL grant_mem: we %b addr %h wd %h exp 1 100 deadbeef", mem_we, mem_addr, mem_wd); end
        mem_rd = 32'h5A5A0001;
        #1;
        n_chk++; if (cp2_rd !== 32'h5A5A0001 || cpu_rd !== 32'h5A5A0001)
            begin n_fail++; $display("FAIL grant_rd: cp2 %h cpu %h exp 5a5a0001", cp2_rd, cpu_rd); end
        tick(8);
        n_chk++; if (HOLD_ACK !== 1'b1) begin n_fail++; $display("FAIL grant_c10_ack: got %b exp 1", HOLD_ACK); end
        HOLD = 0;
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b0 || cpu_stall !== 1'b1 || mem_we !== 1'b0)
            begin n_fail++; $display("FAIL grant_c11: ack %b stall %b we %b exp 0 1 0", HOLD_ACK, cpu_stall, mem_we); end
        tick(1);
        n_chk++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h40)
            begin n_fail++; $display("FAIL grant_c12: stall %b we %b addr %h exp 0 1 40", cpu_stall, mem_we, mem_addr); end
        cp2_we = 0;
    endtask

    task automatic test_drain;
        cpu_we = 1; cpu_busy = 1; HOLD = 1;
        tick(3);
        n_chk++; if (HOLD_ACK !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL drain_c3: ack %b we %b exp 0 0", HOLD_ACK, mem_we); end
        cpu_busy = 0;
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b1) begin n_fail++; $display("FAIL drain_c4_ack: got %b exp 1", HOLD_ACK); end
        HOLD = 0;
        tick(2);
        // busy stuck high: grant forced once the drain budget runs out
        cpu_busy = 1; HOLD = 1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            n_chk++; if (HOLD_ACK !== 1'b0 || mem_we !== 1'b0)
                begin n_fail++; $display("FAIL drain_stuck_c%0d: ack %b we %b exp 0 0", i, HOLD_ACK, mem_we); end
        end
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b1) begin n_fail++; $display("FAIL drain_forced: ack %b exp 1", HOLD_ACK); end
        HOLD = 0;
        tick(2);
        // HOLD withdrawn while draining: release without a grant
        HOLD = 1;
        tick(1);
        HOLD = 0;
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b0 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL drain_abort_rel: ack %b stall %b exp 0 1", HOLD_ACK, cpu_stall); end
        tick(1);
        n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL drain_abort_idle: stall %b exp 0", cpu_stall); end
        cpu_busy = 0;
    endtask

    task automatic test_hold_pair;
        cpu_we = 0; cpu_addr = 32'h80; cpu_wd = 32'hCAFEF00D; cp2_addr = 32'h200;
        HOLD = 1;
        tick(2);
        n_chk++; if (HOLD_ACK !== 1'b1) begin n_fail++; $display("FAIL pair_g1: ack %b exp 1", HOLD_ACK); end
        HOLD = 0;
        tick(1);
        HOLD = 1; cpu_we = 1;
        tick(1);
        n_chk++; if (cpu_stall !== 1'b0 || HOLD_ACK !== 1'b0) begin n_fail++; $display("FAIL pair_idle: stall %b ack %b exp 0 0", cpu_stall, HOLD_ACK); end
        n_chk++; if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wd !== 32'hCAFEF00D)
            begin n_fail++; $display("FAIL pair_cpu_wr: we %b addr %h wd %h exp 1 80 cafef00d", mem_we, mem_addr, mem_wd); end
        cpu_we = 0;
        tick(1);
        n_chk++; if (cpu_stall !== 1'b1 || HOLD_ACK !== 1'b0) begin n_fail++; $display("FAIL pair_drain: stall %b ack %b exp 1 0", cpu_stall, HOLD_ACK); end
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL pair_g2: ack %b addr %h exp 1 200", HOLD_ACK, mem_addr); end
        HOLD = 0;
        tick(2);
    endtask

    task automatic test_interrupt;
        cp2_int = 1;
        tick(1);
        n_chk++; if (int_pend !== 1'b1) begin n_fail++; $display("FAIL int_set: got %b exp 1", int_pend); end
        cp2_int = 0;
        tick(1);
        n_chk++; if (int_pend !== 1'b1) begin n_fail++; $display("FAIL int_hold: got %b exp 1", int_pend); end
        cp2_int = 1; int_ack = 1;
        tick(1);
        n_chk++; if (int_pend !== 1'b1) begin n_fail++; $display("FAIL int_set_wins: got %b exp 1", int_pend); end
        tick(1);
        n_chk++; if (int_pend !== 1'b0) begin n_fail++; $display("FAIL int_ack_clr: got %b exp 0", int_pend); end
        int_ack = 0;
        tick(2);
        n_chk++; if (int_pend !== 1'b0) begin n_fail++; $display("FAIL int_level_no_set: got %b exp 0", int_pend); end
        cp2_int = 0;
        tick(1);
    endtask

`ifdef CP2_ARB_WDT_EN
    task automatic test_wdt;
        HOLD = 1;
        tick(2);
        n_chk++; if (HOLD_ACK !== 1'b1 || wdt_err !== 1'b0) begin n_fail++; $display("FAIL wdt_grant: ack %b err %b exp 1 0", HOLD_ACK, wdt_err); end
        for (int i = 3; i <= 17; i++) begin
            tick(1);
            n_chk++; if (HOLD_ACK !== 1'b1) begin n_fail++; $display("FAIL wdt_held_c%0d: ack %b exp 1", i, HOLD_ACK); end
        end
        tick(1);
        n_chk++; if (HOLD_ACK !== 1'b0 || wdt_err !== 1'b1) begin n_fail++; $display("FAIL wdt_fire: ack %b err %b exp 0 1", HOLD_ACK, wdt_err); end
        tick(1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_chk++; if (HOLD_ACK !== 1'b0 || cpu_stall !== 1'b0)
                begin n_fail++; $display("FAIL wdt_block_%0d: ack %b stall %b exp 0 0", i, HOLD_ACK, cpu_stall); end
        end
        HOLD = 0;
        tick(1);
        HOLD = 1;
        tick(2);
        n_chk++; if (HOLD_ACK !== 1'b1 || wdt_err !== 1'b1) begin n_fail++; $display("FAIL wdt_regrant: ack %b err %b exp 1 1", HOLD_ACK, wdt_err); end
        HOLD = 0;
        tick(2);
    endtask
`endif

    task automatic test_reset_mid_grant;
        cp2_int = 1;
        tick(1);
        cp2_int = 0;
        cpu_addr = 32'h44; cp2_addr = 32'h300;
        HOLD = 1;
        tick(2);
        n_chk++; if (HOLD_ACK !== 1'b1 || int_pend !== 1'b1) begin n_fail++; $display("FAIL rstg_pre: ack %b int %b exp 1 1", HOLD_ACK, int_pend); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (HOLD_ACK !== 1'b0 || cpu_stall !== 1'b0 || int_pend !== 1'b0)
            begin n_fail++; $display("FAIL rstg_async: ack %b stall %b int %b exp 0 0 0", HOLD_ACK, cpu_stall, int_pend); end
        n_chk++; if (mem_addr !== 32'h44) begin n_fail++; $display("FAIL rstg_owner: addr %h exp 44", mem_addr); end
        HOLD = 0;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset;
        test_clean_grant;
        test_drain;
        test_hold_pair;
        test_interrupt;
`ifdef CP2_ARB_WDT_EN
        test_wdt;
`endif
        test_reset_mid_grant;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
